// File: rtl/regfile_bus_scheduler.sv
// Round-robin scheduler sharing the register file's single data bus between NREQ requesters.
// Each access runs as a fixed multi-cycle transaction that ends with a bus turnaround cycle.
module regfile_bus_scheduler #(
    parameter int NREQ = 4,
    parameter int AW   = 8,
    parameter int DW   = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ-1:0]   req_wr,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [NREQ*DW-1:0] req_wdata,
    output logic [NREQ-1:0]   gnt,
    output logic [NREQ-1:0]   done,
    output logic [DW-1:0]     rdata,
    output logic              busy,
    output logic [AW-1:0]     rf_r_addr,
    output logic [AW-1:0]     rf_w_addr,
    output logic              rf_re,
    output logic              rf_we,
    output logic              bus_oe,
    output logic [DW-1:0]     bus_out,
    input  logic [DW-1:0]     bus_in
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [NREQ-1:0] ONE_HOT0 = {{(NREQ-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WR      = 3'd1,
        S_RD_ADDR = 3'd2,
        S_RD_CAP  = 3'd3,
        S_TURN    = 3'd4
    } state_t;

    state_t          state_r;
    logic [IW-1:0]   ptr_r;
    logic [IW-1:0]   owner_r;
    logic [IW-1:0]   win_s;
    logic [IW-1:0]   idx_s;
    logic [IW-1:0]   ptr_nxt_s;
    logic            win_vld_s;

    // Round-robin search: scan offsets from high to low so the smallest offset from ptr wins.
    always_comb begin
        win_s     = ptr_r;
        win_vld_s = 1'b0;
        idx_s     = ptr_r;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx_s = IW'((int'(ptr_r) + k) % NREQ);
            if (req[idx_s]) begin
                win_s     = idx_s;
                win_vld_s = 1'b1;
            end else begin
                win_s     = win_s;
            end
        end
        if (win_s == IW'(NREQ - 1)) begin
            ptr_nxt_s = '0;
        end else begin
            ptr_nxt_s = win_s + IW'(1);
        end
    end

    // Transaction sequencer; every output is a register updated on the transition into its state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= S_IDLE;
            ptr_r     <= '0;
            owner_r   <= '0;
            gnt       <= '0;
            done      <= '0;
            rdata     <= '0;
            busy      <= 1'b0;
            rf_r_addr <= '0;
            rf_w_addr <= '0;
            rf_re     <= 1'b0;
            rf_we     <= 1'b0;
            bus_oe    <= 1'b0;
            bus_out   <= '0;
        end else begin
            gnt  <= '0;
            done <= '0;
            case (state_r)
                S_IDLE: begin
                    if (win_vld_s) begin
                        owner_r <= win_s;
                        gnt     <= ONE_HOT0 << win_s;
                        ptr_r   <= ptr_nxt_s;
                        busy    <= 1'b1;
                        if (req_wr[win_s]) begin
                            state_r   <= S_WR;
                            bus_oe    <= 1'b1;
                            bus_out   <= req_wdata[win_s*DW +: DW];
                            rf_w_addr <= req_addr[win_s*AW +: AW];
                            rf_we     <= 1'b1;
                        end else begin
                            state_r   <= S_RD_ADDR;
                            rf_r_addr <= req_addr[win_s*AW +: AW];
                            rf_re     <= 1'b1;
                        end
                    end else begin
                        state_r <= S_IDLE;
                        busy    <= 1'b0;
                    end
                end
                S_WR: begin
                    state_r <= S_TURN;
                    bus_oe  <= 1'b0;
                    rf_we   <= 1'b0;
                    done    <= ONE_HOT0 << owner_r;
                end
                S_RD_ADDR: begin
                    state_r <= S_RD_CAP;
                end
                S_RD_CAP: begin
                    state_r <= S_TURN;
                    rf_re   <= 1'b0;
                    rdata   <= bus_in;
                    done    <= ONE_HOT0 << owner_r;
                end
                S_TURN: begin
                    state_r <= S_IDLE;
                    busy    <= 1'b0;
                end
                default: begin
                    state_r <= S_IDLE;
                    busy    <= 1'b0;
                    rf_re   <= 1'b0;
                    rf_we   <= 1'b0;
                    bus_oe  <= 1'b0;
                end
            endcase
        end
    end

    regfile_bus_scheduler_checker #(.NREQ(NREQ)) u_checker (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus_oe (bus_oe),
        .rf_re  (rf_re),
        .gnt    (gnt),
        .done   (done)
    );

endmodule

// Bus-contention and handshake-shape properties for the scheduler outputs.
module regfile_bus_scheduler_checker #(
    parameter int NREQ = 4
) (
    input logic            clk,
    input logic            rst_n,
    input logic            bus_oe,
    input logic            rf_re,
    input logic [NREQ-1:0] gnt,
    input logic [NREQ-1:0] done
);

    a_bus_excl: assert property (@(posedge clk) disable iff (!rst_n) !(bus_oe && rf_re));
    a_oe_then_re: assert property (@(posedge clk) disable iff (!rst_n) bus_oe |=> !rf_re);
    a_re_then_oe: assert property (@(posedge clk) disable iff (!rst_n) rf_re |=> !bus_oe);
    a_gnt_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(gnt));
    a_done_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(done));
    a_gnt_done_excl: assert property (@(posedge clk) disable iff (!rst_n) !((|gnt) && (|done)));

endmodule
